// File: rtl/nic_pkg.sv
// ============================================================================
// Module      : nic_pkg
// Description : Shared width, word type and register-map constants for the NIC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nic_pkg;

  localparam int DATA_W = 64;

  typedef logic [0:DATA_W-1] word_t;

  localparam logic [1:0] NIC_IBUF  = 2'b00;
  localparam logic [1:0] NIC_ISTAT = 2'b01;
  localparam logic [1:0] NIC_OBUF  = 2'b10;
  localparam logic [1:0] NIC_OSTAT = 2'b11;

endpackage

`default_nettype wire

// File: rtl/nic_if.sv
// ============================================================================
// Module      : nic_if
// Description : Processor register port plus router handshake, bundled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nic_if;
  import nic_pkg::*;

  logic [0:1] addr;
  word_t      d_in;
  word_t      d_out;
  logic       nicEn;
  logic       nicWrEn;
  logic       net_si;
  logic       net_ri;
  word_t      net_di;
  logic       net_so;
  logic       net_ro;
  word_t      net_do;

  // NIC side
  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro,
    output d_out, net_ri, net_so, net_do
  );

  // Processor / router side
  modport master (
    output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro,
    input  d_out, net_ri, net_so, net_do
  );

endinterface

`default_nettype wire

// File: rtl/nic_buf.sv
// ============================================================================
// Module      : nic_buf
// Description : One-entry data register with full flag; load sets, clear drops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nic_buf
  import nic_pkg::*;
(
  input  logic  CLK,
  input  logic  RESET,
  input  logic  load,
  input  logic  clear,
  input  word_t din,
  output word_t dout,
  output logic  full
);

  word_t r_data;
  logic  r_full;

  // Load takes precedence; callers never request both in one cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (load) begin
      r_data <= din;
      r_full <= 1'b1;
    end else if (clear) begin
      r_full <= 1'b0;
    end
  end

  assign dout = r_data;
  assign full = r_full;

endmodule

`default_nettype wire

// File: rtl/nic.sv
// ============================================================================
// Module      : nic
// Description : Network interface: register decode plus router handshake glue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nic
  import nic_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  nic_if.slave bus
);

  logic  w_rd;
  logic  w_wr;
  logic  w_in_load;
  logic  w_in_clear;
  logic  w_out_load;
  logic  w_out_clear;
  logic  w_in_full;
  logic  w_out_full;
  word_t w_in_data;
  word_t w_out_data;

  assign w_rd = bus.nicEn & ~bus.nicWrEn;
  assign w_wr = bus.nicEn &  bus.nicWrEn;

  // Arrival and processor drain of the input buffer are mutually exclusive
  // because net_ri is low exactly while the buffer holds a packet.
  assign w_in_load  = bus.net_si & ~w_in_full;
  assign w_in_clear = w_rd & (bus.addr == NIC_IBUF) & w_in_full;

  // A write landing in the send cycle sees out_full=1 and is dropped.
  assign w_out_load  = w_wr & (bus.addr == NIC_OBUF) & ~w_out_full;
  assign w_out_clear = w_out_full & bus.net_ro;

  nic_buf u_in_buf (
    .CLK   (CLK),
    .RESET (RESET),
    .load  (w_in_load),
    .clear (w_in_clear),
    .din   (bus.net_di),
    .dout  (w_in_data),
    .full  (w_in_full)
  );

  nic_buf u_out_buf (
    .CLK   (CLK),
    .RESET (RESET),
    .load  (w_out_load),
    .clear (w_out_clear),
    .din   (bus.d_in),
    .dout  (w_out_data),
    .full  (w_out_full)
  );

  assign bus.net_ri = ~w_in_full;
  assign bus.net_so = w_out_full & bus.net_ro;
  assign bus.net_do = w_out_data;

  always_comb begin
    bus.d_out = '0;
    if (w_rd) begin
      case (bus.addr)
        NIC_IBUF:  bus.d_out = w_in_data;
        NIC_ISTAT: bus.d_out = {{(DATA_W-1){1'b0}}, w_in_full};
        NIC_OBUF:  bus.d_out = '0;
        NIC_OSTAT: bus.d_out = {{(DATA_W-1){1'b0}}, w_out_full};
        default:   bus.d_out = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nic.sv
// ============================================================================
// Module      : tb_nic
// Description : Directed self-checking bench for the nic block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nic;
  import nic_pkg::*;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  nic_if bus ();

  nic dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a);
    bus.nicEn   = 1'b1;
    bus.nicWrEn = 1'b0;
    bus.addr    = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    bus.nicEn   = 1'b1;
    bus.nicWrEn = 1'b1;
    bus.addr    = a;
    bus.d_in    = d;
    #1;
  endtask

  task automatic idle();
    bus.nicEn   = 1'b0;
    bus.nicWrEn = 1'b0;
    bus.addr    = 2'b00;
    bus.d_in    = '0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET       = 1'b1;
    bus.addr    = 2'b00;
    bus.d_in    = '0;
    bus.nicEn   = 1'b0;
    bus.nicWrEn = 1'b0;
    bus.net_si  = 1'b0;
    bus.net_di  = '0;
    bus.net_ro  = 1'b0;
    tick();
    tick();
    RESET = 1'b0;

    // Reset state
    idle();
    chk("rst_dout_idle", bus.d_out, 64'h0);
    chk("rst_net_ri", {63'b0, bus.net_ri}, 64'h1);
    chk("rst_net_so", {63'b0, bus.net_so}, 64'h0);
    chk("rst_net_do", bus.net_do, 64'h0);
    rd(NIC_ISTAT);
    chk("rst_istat", bus.d_out, 64'h0);
    rd(NIC_OSTAT);
    chk("rst_ostat", bus.d_out, 64'h0);

    // Single send with router initially not ready
    wr(NIC_OBUF, 64'hDEAD_BEEF_0000_0001);
    tick();
    rd(NIC_OSTAT);
    chk("send_ostat_full", bus.d_out, 64'h1);
    chk("send_so_blocked", {63'b0, bus.net_so}, 64'h0);
    rd(NIC_OBUF);
    chk("send_obuf_read_zero", bus.d_out, 64'h0);
    idle();
    bus.net_ro = 1'b1;
    #1;
    chk("send_so_high", {63'b0, bus.net_so}, 64'h1);
    chk("send_do", bus.net_do, 64'hDEAD_BEEF_0000_0001);
    tick();
    chk("send_so_one_cycle", {63'b0, bus.net_so}, 64'h0);
    rd(NIC_OSTAT);
    chk("send_ostat_clear", bus.d_out, 64'h0);
    bus.net_ro = 1'b0;

    // Second write while full is dropped
    wr(NIC_OBUF, 64'hAAAA_0000_0000_0001);
    tick();
    wr(NIC_OBUF, 64'hBBBB_0000_0000_0002);
    tick();
    idle();
    chk("drop_do_keeps_a", bus.net_do, 64'hAAAA_0000_0000_0001);
    bus.net_ro = 1'b1;
    #1;
    chk("drop_send_a", bus.net_do, 64'hAAAA_0000_0000_0001);
    chk("drop_so", {63'b0, bus.net_so}, 64'h1);
    tick();
    bus.net_ro = 1'b0;

    // Write in the same cycle as a send is dropped
    wr(NIC_OBUF, 64'hCCCC_0000_0000_0003);
    tick();
    bus.net_ro = 1'b1;
    wr(NIC_OBUF, 64'hDDDD_0000_0000_0004);
    tick();
    bus.net_ro = 1'b0;
    rd(NIC_OSTAT);
    chk("samecyc_ostat", bus.d_out, 64'h0);
    chk("samecyc_do", bus.net_do, 64'hCCCC_0000_0000_0003);

    // Packet arrival and processor drain
    idle();
    bus.net_si = 1'b1;
    bus.net_di = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("arr_ri_before", {63'b0, bus.net_ri}, 64'h1);
    tick();
    bus.net_si = 1'b0;
    bus.net_di = '0;
    #1;
    chk("arr_ri_low", {63'b0, bus.net_ri}, 64'h0);
    rd(NIC_ISTAT);
    chk("arr_istat", bus.d_out, 64'h1);
    rd(NIC_IBUF);
    chk("arr_ibuf", bus.d_out, 64'h0123_4567_89AB_CDEF);
    tick();
    idle();
    chk("arr_ri_back", {63'b0, bus.net_ri}, 64'h1);
    rd(NIC_ISTAT);
    chk("arr_istat_clear", bus.d_out, 64'h0);
    rd(NIC_IBUF);
    chk("arr_stale_ibuf", bus.d_out, 64'h0123_4567_89AB_CDEF);
    tick();
    rd(NIC_ISTAT);
    chk("arr_stale_flag", bus.d_out, 64'h0);

    // Held packet while the input buffer is full
    idle();
    bus.net_si = 1'b1;
    bus.net_di = 64'h1111_2222_3333_4444;
    tick();
    bus.net_di = 64'h5555_6666_7777_8888;
    #1;
    chk("hold_ri_low", {63'b0, bus.net_ri}, 64'h0);
    tick();
    rd(NIC_IBUF);
    chk("hold_first_kept", bus.d_out, 64'h1111_2222_3333_4444);
    tick();
    idle();
    chk("hold_ri_after_read", {63'b0, bus.net_ri}, 64'h1);
    tick();
    bus.net_si = 1'b0;
    bus.net_di = '0;
    rd(NIC_ISTAT);
    chk("hold_second_flag", bus.d_out, 64'h1);
    rd(NIC_IBUF);
    chk("hold_second_data", bus.d_out, 64'h5555_6666_7777_8888);
    tick();

    // Reset with both buffers full
    wr(NIC_OBUF, 64'h9999_0000_0000_0009);
    bus.net_si = 1'b1;
    bus.net_di = 64'hEEEE_0000_0000_000E;
    tick();
    idle();
    bus.net_si = 1'b0;
    #1;
    chk("full_ri_low", {63'b0, bus.net_ri}, 64'h0);
    rd(NIC_OSTAT);
    chk("full_ostat", bus.d_out, 64'h1);
    RESET = 1'b1;
    bus.net_ro = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    chk("rst2_so", {63'b0, bus.net_so}, 64'h0);
    chk("rst2_ri", {63'b0, bus.net_ri}, 64'h1);
    chk("rst2_do", bus.net_do, 64'h0);
    rd(NIC_IBUF);
    chk("rst2_ibuf", bus.d_out, 64'h0);
    rd(NIC_ISTAT);
    chk("rst2_istat", bus.d_out, 64'h0);
    rd(NIC_OSTAT);
    chk("rst2_ostat", bus.d_out, 64'h0);
    bus.net_ro = 1'b0;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nic.md
NIC -- requirements
Module: nic

Interface
REQ-001 DATA_W, 64, processor and network data width.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 addr  input  [0:1]  register select: 00 = input buffer, 01 = input status, 10 = output buffer, 11 = output status.
REQ-005 d_in  input  [0:63]  processor write data.
REQ-006 d_out  output  [0:63]  processor read data.
REQ-007 nicEn  input  1  access enable.
REQ-008 nicWrEn  input  1  write when high, read when low; qualified by nicEn.
REQ-009 net_si  input  1  router presents a packet on net_di.
REQ-010 net_ri  output  1  NIC can accept a packet from the router.
REQ-011 net_di  input  [0:63]  packet from router.
REQ-012 net_so  output  1  NIC presents a packet on net_do.
REQ-013 net_ro  input  1  router can accept a packet.
REQ-014 net_do  output  [0:63]  packet to router.

Function
REQ-015 The NIC SHALL hold one 64-bit input buffer with flag in_full, and one 64-bit output buffer with flag out_full.
REQ-016 Reads SHALL be combinational: with nicEn=1 and nicWrEn=0, d_out reflects the selected register in the same cycle.
REQ-017 When no read is active, d_out SHALL be 0.
REQ-018 Read of 00 SHALL return the input buffer and clear in_full at the next posedge; if in_full=0, it SHALL return the stale buffer and leave the flag unchanged.
REQ-019 Read of 01 SHALL return 63'b0 followed by in_full in bit 63.
REQ-020 Read of 11 SHALL return 63'b0 followed by out_full in bit 63.
REQ-021 Read of 10 SHALL return 0.
REQ-022 Write to 10 with out_full=0 SHALL load d_in into the output buffer and set out_full at the posedge.
REQ-023 Write to 10 with out_full=1 SHALL be dropped; buffer and flag are unchanged.
REQ-024 Writes to 00, 01 and 11 SHALL be ignored.
REQ-025 net_ri SHALL equal ~in_full, combinationally.
REQ-026 At a posedge where net_si and net_ri are both 1, the NIC SHALL load net_di and set in_full.
REQ-027 If net_si=1 while net_ri=0, the packet SHALL be ignored; the router must hold it.
REQ-028 net_so SHALL equal out_full AND net_ro; net_do SHALL always drive the output buffer.
REQ-029 At a posedge where net_so=1, out_full SHALL clear, giving one-cycle transfer latency.
REQ-030 A processor write to 10 in the same cycle as a send SHALL be dropped, because out_full is still 1 in that cycle.
REQ-031 A processor read of 00 in the same cycle as an arrival cannot occur, because net_ri=0 whenever in_full=1; no priority logic is required.
REQ-032 Back-to-back writes SHALL be accepted one per two cycles at most: write, send, then the next write.

Reset
REQ-033 On RESET=1 at a posedge, both buffers and both flags SHALL clear to 0.
REQ-034 With flags clear, outputs SHALL be net_ri=1, net_so=0, net_do=0; d_out SHALL follow REQ-016/017.
REQ-035 RESET asserted mid-transfer SHALL discard buffered packets, with no partial send.

Structure
REQ-036 A shared package nic_pkg SHALL hold DATA_W and the four address constants (NIC_IBUF, NIC_ISTAT, NIC_OBUF, NIC_OSTAT).
REQ-037 One sub-module nic_buf SHALL implement a one-entry register with full flag and load/clear controls; it is instantiated twice.
REQ-038 The top level SHALL contain only the address decode and the network glue.

Verification
REQ-039 After reset, read 01 and 11 -> d_out=0; net_ri=1; net_so=0.
REQ-040 Write 10 with 64'hDEAD_BEEF_0000_0001 while net_ro=0 -> status 11 reads 1, net_so=0; raise net_ro -> net_so=1 for exactly one cycle with net_do=DEAD_BEEF_0000_0001, then 11 reads 0.
REQ-041 Write 10 with value A, then immediately write 10 with value B while net_ro=0 -> B dropped; the later send carries A.
REQ-042 net_si=1 with net_di=64'h0123_4567_89AB_CDEF -> net_ri falls next cycle; 01 reads 1; read 00 returns 0123_4567_89AB_CDEF; net_ri returns to 1 the cycle after.
REQ-043 Hold net_si=1 with a second packet while in_full=1 -> packet not latched; after the processor reads 00 it is latched the following cycle.
REQ-044 Fill both buffers, assert RESET for one cycle -> both flags 0, net_so=0, net_ri=1, and 00 reads 0.
